// File: rtl/extend_unit_pipe.sv
// Registered sign/zero/upper field extension with a DEPTH-entry output FIFO.
// Optional hit counter for negative sign-mode pushes when EXTEND_STATS_EN is defined.
module extend_unit_pipe #(
   parameter int unsigned IN_W  = 5,
   parameter int unsigned OUT_W = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic             out_err,
`ifdef EXTEND_STATS_EN
   input  logic             stats_clr,
   output logic [15:0]      neg_count,
`endif
   output logic [1:0]       occupancy
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      MODE_SIGN  = 2'b00,
      MODE_ZERO  = 2'b01,
      MODE_UPPER = 2'b10,
      MODE_RSVD  = 2'b11
   } mode_t;

   function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] d, input mode_t m);
      case (m)
         MODE_ZERO:  return {{(OUT_W-IN_W){1'b0}}, d};
         MODE_UPPER: return {d, {(OUT_W-IN_W){1'b0}}};
         default:    return {{(OUT_W-IN_W){d[IN_W-1]}}, d};
      endcase
   endfunction

   function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
      if (p == PW'(DEPTH-1)) return '0;
      return p + 1'b1;
   endfunction

   // Each entry carries the reserved-mode error flag above the data bits.
   logic [OUT_W:0]  mem [DEPTH];
   logic [PW-1:0]   head;
   logic [PW-1:0]   tail;
   logic [1:0]      count;

   mode_t           mode;
   logic            push;
   logic            pop;
   logic [OUT_W:0]  new_entry;
   logic [PW-1:0]   head_nxt;
   logic [1:0]      count_nxt;
   logic [OUT_W:0]  head_entry_nxt;

   assign mode      = mode_t'(in_mode);
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign new_entry = {mode == MODE_RSVD, extend(in_data, mode)};
   assign occupancy = count;

   always_comb begin
      head_nxt  = pop ? inc_ptr(head) : head;
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 2'd1;
         2'b01:   count_nxt = count - 2'd1;
         default: count_nxt = count;
      endcase
      // The entry being written this edge is not yet in mem; forward it when it becomes head.
      if (push && (head_nxt == tail)) head_entry_nxt = new_entry;
      else                            head_entry_nxt = mem[head_nxt];
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_err   <= 1'b0;
      end else begin
         if (push) begin
            mem[tail] <= new_entry;
            tail      <= inc_ptr(tail);
         end
         head      <= head_nxt;
         count     <= count_nxt;
         in_ready  <= (count_nxt < 2'(DEPTH));
         out_valid <= (count_nxt != 2'd0);
         // When the buffer drains, out_data keeps the last popped value.
         if (count_nxt != 2'd0) begin
            out_data <= head_entry_nxt[OUT_W-1:0];
            out_err  <= head_entry_nxt[OUT_W];
         end
      end
   end

`ifdef EXTEND_STATS_EN
   always_ff @(posedge clock) begin
      if (!reset_n || stats_clr)
         neg_count <= '0;
      else if (push && (mode == MODE_SIGN) && in_data[IN_W-1] && (neg_count != 16'hFFFF))
         neg_count <= neg_count + 16'd1;
   end
`endif

endmodule

// File: tb/tb_extend_unit_pipe.sv
// Self-checking bench for extend_unit_pipe: directed scenarios plus a randomized
// run scored against a queue-based model. Covers the counter if EXTEND_STATS_EN is defined.
module tb_extend_unit_pipe;

   localparam int unsigned IN_W  = 5;
   localparam int unsigned OUT_W = 32;
   localparam int unsigned DEPTH = 2;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [IN_W-1:0]  in_data = '0;
   logic [1:0]       in_mode = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [OUT_W-1:0] out_data;
   logic             out_err;
   logic [1:0]       occupancy;
`ifdef EXTEND_STATS_EN
   logic             stats_clr = 1'b0;
   logic [15:0]      neg_count;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   extend_unit_pipe #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
      .clock     (clock),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_err   (out_err),
`ifdef EXTEND_STATS_EN
      .stats_clr (stats_clr),
      .neg_count (neg_count),
`endif
      .occupancy (occupancy)
   );

   always #5 clock = ~clock;

   // Reference extension from the arithmetic meaning of each mode.
   function automatic logic [31:0] ref_ext(input int unsigned d, input int unsigned m);
      int v;
      if (m == 1) return 32'(d);
      if (m == 2) return 32'(d * (2 ** (OUT_W - IN_W)));
      v = (d >= 2 ** (IN_W - 1)) ? int'(d) - (2 ** IN_W) : int'(d);
      return 32'(v);
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      step();
      step();
      n_cmp++; if (occupancy !== 2'd0) begin n_fail++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
      n_cmp++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=0", out_data); end
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready_low got=%b exp=0", in_ready); end
      reset_n = 1'b1;
      step();
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready_rise got=%b exp=1", in_ready); end
   endtask

   task automatic test_mode_sweep();
      logic [31:0] exp_tab [4];
      exp_tab[0] = 32'hFFFFFFF6;
      exp_tab[1] = 32'h00000016;
      exp_tab[2] = 32'hB0000000;
      exp_tab[3] = 32'hFFFFFFF6;
      out_ready = 1'b1;
      for (int m = 0; m < 4; m++) begin
         in_valid = 1'b1; in_data = 5'b10110; in_mode = 2'(m);
         step();
         in_valid = 1'b0;
         n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL sweep_valid mode=%0d got=%b exp=1", m, out_valid); end
         n_cmp++; if (out_data !== exp_tab[m]) begin n_fail++; $display("FAIL sweep_data mode=%0d got=%h exp=%h", m, out_data, exp_tab[m]); end
         n_cmp++; if (out_err !== (m == 3)) begin n_fail++; $display("FAIL sweep_err mode=%0d got=%b exp=%b", m, out_err, m == 3); end
         step();
         n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL sweep_pop mode=%0d got=%b exp=0", m, out_valid); end
      end
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; in_mode = 2'b00; in_data = 5'b00011;
      step();
      in_data = 5'b11111;
      step();
      n_cmp++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_full_occ got=%0d exp=2", occupancy); end
      n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready got=%b exp=0", in_ready); end
      in_data = 5'b00111;
      step();
      in_valid = 1'b0;
      n_cmp++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL bp_third_push got=%0d exp=2", occupancy); end
      n_cmp++; if (out_data !== 32'h00000003) begin n_fail++; $display("FAIL bp_head0 got=%h exp=00000003", out_data); end
      out_ready = 1'b1;
      step();
      n_cmp++; if (out_data !== 32'hFFFFFFFF || out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_head1 got=%h/%b exp=ffffffff/1", out_data, out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_rise got=%b exp=1", in_ready); end
      step();
      n_cmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin n_fail++; $display("FAIL bp_drain got=%b/%0d exp=0/0", out_valid, occupancy); end
      n_cmp++; if (out_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL bp_hold got=%h exp=ffffffff", out_data); end
   endtask

   task automatic test_streaming();
      out_ready = 1'b1;
      in_mode = 2'b01;
      for (int i = 0; i < 20; i++) begin
         in_valid = 1'b1; in_data = 5'(i);
         step();
         n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'(i)) begin n_fail++; $display("FAIL stream_data i=%0d got=%h/%b exp=%h/1", i, out_data, out_valid, 32'(i)); end
         n_cmp++; if (occupancy !== 2'd1) begin n_fail++; $display("FAIL stream_occ i=%0d got=%0d exp=1", i, occupancy); end
      end
      in_valid = 1'b0;
      step();
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drain got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_mid();
      out_ready = 1'b0;
      in_valid = 1'b1; in_mode = 2'b00;
      in_data = 5'($urandom_range(31)); step();
      in_data = 5'($urandom_range(31)); step();
      in_valid = 1'b0;
      n_cmp++; if (occupancy !== 2'd2) begin n_fail++; $display("FAIL rmid_pre got=%0d exp=2", occupancy); end
      reset_n = 1'b0;
      step();
      n_cmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_clear got=%0d/%b exp=0/0", occupancy, out_valid); end
      reset_n = 1'b1;
      step();
      in_valid = 1'b1; in_data = 5'b00001;
      step();
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h00000001) begin n_fail++; $display("FAIL rmid_push got=%h/%b exp=00000001/1", out_data, out_valid); end
      out_ready = 1'b1;
      step();
   endtask

   task automatic test_random();
      logic [32:0] q [$];
      logic [32:0] e;
      int unsigned d, m;
      bit pushed, popped;
      for (int c = 0; c < 400; c++) begin
         n_cmp++; if (occupancy !== 2'(q.size())) begin n_fail++; $display("FAIL rand_occ c=%0d got=%0d exp=%0d", c, occupancy, q.size()); end
         n_cmp++; if (in_ready !== (q.size() < DEPTH)) begin n_fail++; $display("FAIL rand_ready c=%0d got=%b exp=%b", c, in_ready, q.size() < DEPTH); end
         n_cmp++; if (out_valid !== (q.size() > 0)) begin n_fail++; $display("FAIL rand_valid c=%0d got=%b exp=%b", c, out_valid, q.size() > 0); end
         if (q.size() > 0) begin
            n_cmp++; if ({out_err, out_data} !== q[0]) begin n_fail++; $display("FAIL rand_head c=%0d got=%b/%h exp=%b/%h", c, out_err, out_data, q[0][32], q[0][31:0]); end
         end
         d = $urandom_range(31);
         m = $urandom_range(3);
         in_valid  = ($urandom_range(3) != 0);
         out_ready = ($urandom_range(2) != 0);
         in_data = 5'(d); in_mode = 2'(m);
         pushed = in_valid && (q.size() < DEPTH);
         popped = out_ready && (q.size() > 0);
         if (popped) void'(q.pop_front());
         if (pushed) begin
            e = {m == 3, ref_ext(d, m)};
            q.push_back(e);
         end
         step();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      step(); step();
   endtask

`ifdef EXTEND_STATS_EN
   task automatic test_stats();
      logic [4:0] vals [4];
      logic [1:0] modes [4];
      vals[0] = 5'b10000; modes[0] = 2'b00;
      vals[1] = 5'b00001; modes[1] = 2'b00;
      vals[2] = 5'b11111; modes[2] = 2'b00;
      vals[3] = 5'b10000; modes[3] = 2'b01;
      out_ready = 1'b1;
      stats_clr = 1'b1;
      step();
      stats_clr = 1'b0;
      n_cmp++; if (neg_count !== 16'd0) begin n_fail++; $display("FAIL stats_pre_clr got=%0d exp=0", neg_count); end
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = vals[i]; in_mode = modes[i];
         step();
      end
      in_valid = 1'b0;
      n_cmp++; if (neg_count !== 16'd2) begin n_fail++; $display("FAIL stats_count got=%0d exp=2", neg_count); end
      stats_clr = 1'b1; in_valid = 1'b1; in_data = 5'b11000; in_mode = 2'b00;
      step();
      stats_clr = 1'b0; in_valid = 1'b0;
      n_cmp++; if (neg_count !== 16'd0) begin n_fail++; $display("FAIL stats_clr_wins got=%0d exp=0", neg_count); end
      step();
   endtask
`endif

   initial begin
      test_reset();
      test_mode_sweep();
      test_backpressure();
      test_streaming();
      test_reset_mid();
      test_random();
`ifdef EXTEND_STATS_EN
      test_stats();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
